// File: rtl/bank_read_serializer_if.sv
// Bank read serializer bus: flattened bank words in, one selected word out.
// Carries burst request fields, downstream accept and the output word/status.
// slave modport is the serializer's view; master is the driver/consumer view.
interface bank_read_serializer_if #(
  parameter int D_WIDTH   = 64,
  parameter int NUM_BANKS = 16
);
  localparam int SEL_W = $clog2(NUM_BANKS);

  logic [NUM_BANKS*D_WIDTH-1:0] Q_in;
  logic                         start;
  logic [SEL_W-1:0]             start_bank;
  logic [SEL_W:0]               burst_len;
  logic                         out_ready;
  logic [D_WIDTH-1:0]           Q_out;
  logic                         out_valid;
  logic                         out_last;
  logic                         busy;
  logic [SEL_W-1:0]             cur_bank;
  logic                         start_err;

  modport slave (
    input  Q_in, start, start_bank, burst_len, out_ready,
    output Q_out, out_valid, out_last, busy, cur_bank, start_err
  );

  modport master (
    output Q_in, start, start_bank, burst_len, out_ready,
    input  Q_out, out_valid, out_last, busy, cur_bank, start_err
  );
endinterface

// File: rtl/bank_read_serializer.sv
// Serializes a burst of consecutive bank words (wrapping modulo NUM_BANKS) onto Q_out.
// Latency: first word valid one cycle after an accepted start, then one word per cycle.
// Backpressure: out_ready=0 holds word, bank index, last flag and count; starts while busy are rejected.
module bank_read_serializer #(
  parameter int D_WIDTH   = 64,
  parameter int NUM_BANKS = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  bank_read_serializer_if.slave bus
);
  localparam int SEL_W = $clog2(NUM_BANKS);
  localparam logic [SEL_W:0]   NB        = (SEL_W+1)'(NUM_BANKS);
  localparam logic [SEL_W:0]   ONE       = (SEL_W+1)'(1);
  localparam logic [SEL_W-1:0] LAST_BANK = SEL_W'(NUM_BANKS - 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t             state, state_n;
  logic [D_WIDTH-1:0] q_reg, word;
  logic [SEL_W-1:0]   bank_reg, next_bank, sel;
  logic [SEL_W:0]     count;
  logic               err_reg, err_n, load, advance, start_ok;

  // Next-state decode, start validation and bank selection for the next load.
  always_comb begin
    state_n   = state;
    load      = 1'b0;
    advance   = 1'b0;
    err_n     = 1'b0;
    start_ok  = ({1'b0, bus.start_bank} < NB) && (bus.burst_len != '0) && (bus.burst_len <= NB);
    // Explicit wrap so non-power-of-two bank counts roll over to 0.
    next_bank = (bank_reg == LAST_BANK) ? '0 : bank_reg + 1'b1;
    case (state)
      IDLE: begin
        if (bus.start) begin
          if (start_ok) begin
            load    = 1'b1;
            state_n = RUN;
          end else begin
            err_n = 1'b1;
          end
        end
      end
      RUN: begin
        // Any start seen while running is refused, including on the completing edge.
        if (bus.start) err_n = 1'b1;
        if (bus.out_ready) begin
          if (count == ONE) state_n = IDLE;
          else              advance = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
    sel  = load ? bus.start_bank : next_bank;
    word = bus.Q_in[int'(sel)*D_WIDTH +: D_WIDTH];
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  // Output word, bank index, remaining count and error pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_reg    <= '0;
      bank_reg <= '0;
      count    <= '0;
      err_reg  <= 1'b0;
    end else begin
      err_reg <= err_n;
      if (load) begin
        q_reg    <= word;
        bank_reg <= bus.start_bank;
        count    <= bus.burst_len;
      end else if (state == RUN && bus.out_ready) begin
        // Final transfer just drains the count; word and index stay visible.
        count <= count - 1'b1;
        if (advance) begin
          q_reg    <= word;
          bank_reg <= next_bank;
        end
      end
    end
  end

  assign bus.Q_out     = q_reg;
  assign bus.out_valid = (state == RUN);
  assign bus.out_last  = (state == RUN) && (count == ONE);
  assign bus.busy      = (state == RUN);
  assign bus.cur_bank  = bank_reg;
  assign bus.start_err = err_reg;
endmodule

// File: tb/tb_bank_read_serializer.sv
// Directed bench for bank_read_serializer: a 16-bank and a 12-bank instance.
// Bank k holds 0x100+k unless a step overrides it.
// Outputs are sampled 1 time unit after each rising edge.
module tb_bank_read_serializer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  bank_read_serializer_if #(.D_WIDTH(16), .NUM_BANKS(16)) ia ();
  bank_read_serializer_if #(.D_WIDTH(16), .NUM_BANKS(12)) ib ();

  bank_read_serializer #(.D_WIDTH(16), .NUM_BANKS(16)) dut_a (.clk(clk), .rst(rst), .bus(ia.slave));
  bank_read_serializer #(.D_WIDTH(16), .NUM_BANKS(12)) dut_b (.clk(clk), .rst(rst), .bus(ib.slave));

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input int exp);
    total++;
    assert (obs === 32'(exp)) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_a(input string tag, input int q, input int v, input int l,
                       input int cb, input int b, input int e);
    chk({tag, "/Q_out"},     32'(ia.Q_out),     q);
    chk({tag, "/out_valid"}, 32'(ia.out_valid), v);
    chk({tag, "/out_last"},  32'(ia.out_last),  l);
    chk({tag, "/cur_bank"},  32'(ia.cur_bank),  cb);
    chk({tag, "/busy"},      32'(ia.busy),      b);
    chk({tag, "/start_err"}, 32'(ia.start_err), e);
  endtask

  task automatic chk_b(input string tag, input int q, input int v, input int l,
                       input int cb, input int b, input int e);
    chk({tag, "/Q_out"},     32'(ib.Q_out),     q);
    chk({tag, "/out_valid"}, 32'(ib.out_valid), v);
    chk({tag, "/out_last"},  32'(ib.out_last),  l);
    chk({tag, "/cur_bank"},  32'(ib.cur_bank),  cb);
    chk({tag, "/busy"},      32'(ib.busy),      b);
    chk({tag, "/start_err"}, 32'(ib.start_err), e);
  endtask

  task automatic set_a(input int base);
    for (int k = 0; k < 16; k++) ia.Q_in[k*16 +: 16] = 16'(base + k);
  endtask

  task automatic set_b(input int base);
    for (int k = 0; k < 12; k++) ib.Q_in[k*16 +: 16] = 16'(base + k);
  endtask

  task automatic start_a(input int bank, input int len);
    ia.start      = 1'b1;
    ia.start_bank = 4'(bank);
    ia.burst_len  = 5'(len);
  endtask

  initial begin
    int exp_bank;
    set_a(16'h100);
    set_b(16'h100);
    ia.start = 1'b0; ia.start_bank = '0; ia.burst_len = '0; ia.out_ready = 1'b1;
    ib.start = 1'b0; ib.start_bank = '0; ib.burst_len = '0; ib.out_ready = 1'b1;

    // Reset values
    step; step;
    chk_a("reset_a", 0, 0, 0, 0, 0, 0);
    chk_b("reset_b", 0, 0, 0, 0, 0, 0);
    rst = 1'b0;

    // Basic burst 3..6
    start_a(3, 4);
    step; chk_a("b33_w0", 16'h103, 1, 0, 3, 1, 0);
    ia.start = 1'b0;
    step; chk_a("b33_w1", 16'h104, 1, 0, 4, 1, 0);
    step; chk_a("b33_w2", 16'h105, 1, 0, 5, 1, 0);
    step; chk_a("b33_w3", 16'h106, 1, 1, 6, 1, 0);
    step; chk_a("b33_done", 16'h106, 0, 0, 6, 0, 0);

    // Wrap on 16 banks: 14,15,0,1,2
    start_a(14, 5);
    for (int i = 0; i < 5; i++) begin
      step;
      ia.start = 1'b0;
      exp_bank = (14 + i) % 16;
      chk_a($sformatf("wrap16_%0d", i), 16'h100 + exp_bank, 1, (i == 4) ? 1 : 0, exp_bank, 1, 0);
    end
    step; chk_a("wrap16_done", 16'h102, 0, 0, 2, 0, 0);

    // 12-bank instance: out-of-range start bank rejected, then wrap 10,11,0,1
    ib.start = 1'b1; ib.start_bank = 4'd13; ib.burst_len = 5'd1;
    step; chk_b("b12_badbank", 0, 0, 0, 0, 0, 1);
    ib.start_bank = 4'd10; ib.burst_len = 5'd4;
    for (int i = 0; i < 4; i++) begin
      step;
      ib.start = 1'b0;
      exp_bank = (10 + i) % 12;
      chk_b($sformatf("wrap12_%0d", i), 16'h100 + exp_bank, 1, (i == 3) ? 1 : 0, exp_bank, 1, 0);
    end
    step; chk_b("wrap12_done", 16'h101, 0, 0, 1, 0, 0);

    // Backpressure with changing bank data
    start_a(0, 3);
    step; chk_a("bp_w0", 16'h100, 1, 0, 0, 1, 0);
    ia.start = 1'b0;
    ia.out_ready = 1'b0;
    set_a(16'h200);
    for (int i = 0; i < 3; i++) begin
      step; chk_a($sformatf("bp_hold%0d", i), 16'h100, 1, 0, 0, 1, 0);
    end
    ia.out_ready = 1'b1;
    set_a(16'h100);
    step; chk_a("bp_w1", 16'h101, 1, 0, 1, 1, 0);
    step; chk_a("bp_w2", 16'h102, 1, 1, 2, 1, 0);
    step; chk_a("bp_done", 16'h102, 0, 0, 2, 0, 0);

    // Rejected starts: in RUN, on the completing edge, len 0, len 17
    start_a(2, 4);
    step; chk_a("rej_w0", 16'h102, 1, 0, 2, 1, 0);
    start_a(9, 2);
    step; chk_a("rej_run", 16'h103, 1, 0, 3, 1, 1);
    ia.start = 1'b0;
    step; chk_a("rej_w2", 16'h104, 1, 0, 4, 1, 0);
    step; chk_a("rej_w3", 16'h105, 1, 1, 5, 1, 0);
    start_a(0, 1);
    step; chk_a("rej_complete", 16'h105, 0, 0, 5, 0, 1);
    ia.start = 1'b0;
    step; chk_a("rej_clear1", 16'h105, 0, 0, 5, 0, 0);
    start_a(1, 0);
    step; chk_a("rej_len0", 16'h105, 0, 0, 5, 0, 1);
    ia.start = 1'b0;
    step; chk_a("rej_clear2", 16'h105, 0, 0, 5, 0, 0);
    start_a(1, 17);
    step; chk_a("rej_len17", 16'h105, 0, 0, 5, 0, 1);
    ia.start = 1'b0;
    step; chk_a("rej_clear3", 16'h105, 0, 0, 5, 0, 0);

    // Asynchronous reset during the second word of an 8-word burst
    start_a(0, 8);
    step; chk_a("ar_w0", 16'h100, 1, 0, 0, 1, 0);
    ia.start = 1'b0;
    step; chk_a("ar_w1", 16'h101, 1, 0, 1, 1, 0);
    #3 rst = 1'b1;
    #1 chk_a("ar_async", 0, 0, 0, 0, 0, 0);
    step; rst = 1'b0;
    start_a(5, 1);
    step; chk_a("ar_single", 16'h105, 1, 1, 5, 1, 0);
    ia.start = 1'b0;
    step; chk_a("ar_single_done", 16'h105, 0, 0, 5, 0, 0);

    // Full-length burst from bank 7
    start_a(7, 16);
    for (int i = 0; i < 16; i++) begin
      step;
      ia.start = 1'b0;
      exp_bank = (7 + i) % 16;
      chk_a($sformatf("full_%0d", i), 16'h100 + exp_bank, 1, (i == 15) ? 1 : 0, exp_bank, 1, 0);
    end
    step; chk_a("full_done", 16'h106, 0, 0, 6, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
